// File: rtl/glb_cfg_arb_pkg.sv
// Shared types and constants for the global-buffer config-bus arbiter.
package glb_cfg_arb_pkg;
  localparam int NUM_REQ    = 2;
  localparam int MAX_DWIDTH = 256;

  // Returned in place of slave data when a read response never arrives.
  localparam logic [MAX_DWIDTH-1:0] TIMEOUT_DATA = '1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
    RETURN
  } state_t;
endpackage

// File: rtl/glb_cfg_rr_arbiter.sv
// Two-input round-robin grant: on contention the requester that was not granted last wins.
module glb_cfg_rr_arbiter
  import glb_cfg_arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = req;
    if (&req) grant = last_grant ? 2'b01 : 2'b10;
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 last_grant <= 1'b1;
    else if (update && |req)   last_grant <= grant[1];
  end

endmodule

// File: rtl/glb_cfg_arbiter.sv
// Shares one config slave port between two bridges, one transaction at a time, round-robin.
// Optional read-response timeout enabled by defining GLB_CFG_ARB_TIMEOUT_EN.
module glb_cfg_arbiter
  import glb_cfg_arb_pkg::*;
#(
  parameter int AWIDTH  = 12,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_wr_en,
  input  logic              req0_rd_en,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_wr_data,
  output logic              req0_ready,
  output logic [DWIDTH-1:0] req0_rd_data,
  output logic              req0_rd_data_valid,
  input  logic              req1_wr_en,
  input  logic              req1_rd_en,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_wr_data,
  output logic              req1_ready,
  output logic [DWIDTH-1:0] req1_rd_data,
  output logic              req1_rd_data_valid,
  output logic              cfg_wr_en,
  output logic              cfg_wr_clk_en,
  output logic              cfg_rd_en,
  output logic              cfg_rd_clk_en,
  output logic [AWIDTH-1:0] cfg_wr_addr,
  output logic [AWIDTH-1:0] cfg_rd_addr,
  output logic [DWIDTH-1:0] cfg_wr_data,
  input  logic [DWIDTH-1:0] cfg_rd_data,
  input  logic              cfg_rd_data_valid,
  output logic              rd_timeout_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("glb_cfg_arbiter: TIMEOUT must be at least 1");
  end

  state_t              state;
  logic                owner;
  logic                is_wr;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  grant;
  logic                idle;
  logic                sel_wr;
  logic [AWIDTH-1:0]   sel_addr;
  logic [DWIDTH-1:0]   sel_data;
  logic                tmo_expired;
  logic [DWIDTH-1:0]   ret_data;

  assign idle = (state == IDLE);
  assign req  = {req1_wr_en | req1_rd_en, req0_wr_en | req0_rd_en};

  glb_cfg_rr_arbiter u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (idle),
    .grant  (grant)
  );

  // A simultaneous wr/rd request is treated as a write.
  assign sel_wr   = grant[1] ? req1_wr_en   : req0_wr_en;
  assign sel_addr = grant[1] ? req1_addr    : req0_addr;
  assign sel_data = grant[1] ? req1_wr_data : req0_wr_data;

  assign req0_ready = ~reset & idle & grant[0];
  assign req1_ready = ~reset & idle & grant[1];

  assign cfg_wr_clk_en = cfg_wr_en;
  assign cfg_rd_clk_en = cfg_rd_en;
  assign cfg_rd_addr   = cfg_wr_addr;

  assign ret_data = cfg_rd_data_valid ? cfg_rd_data : TIMEOUT_DATA[DWIDTH-1:0];

`ifdef GLB_CFG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_err_q;

  // Counter sits at zero outside RD_WAIT, so it is cleared on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt   <= (state == RD_WAIT) ? tmo_cnt + 1'b1 : '0;
      tmo_err_q <= tmo_expired & ~cfg_rd_data_valid;
    end
  end

  assign tmo_expired    = (state == RD_WAIT) && (tmo_cnt == CW'(TIMEOUT - 1));
  assign rd_timeout_err = tmo_err_q;
`else
  assign tmo_expired    = 1'b0;
  assign rd_timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      owner              <= 1'b0;
      is_wr              <= 1'b0;
      cfg_wr_en          <= 1'b0;
      cfg_rd_en          <= 1'b0;
      cfg_wr_addr        <= '0;
      cfg_wr_data        <= '0;
      req0_rd_data       <= '0;
      req1_rd_data       <= '0;
      req0_rd_data_valid <= 1'b0;
      req1_rd_data_valid <= 1'b0;
    end else begin
      cfg_wr_en          <= 1'b0;
      cfg_rd_en          <= 1'b0;
      req0_rd_data_valid <= 1'b0;
      req1_rd_data_valid <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          owner       <= grant[1];
          is_wr       <= sel_wr;
          cfg_wr_addr <= sel_addr;
          cfg_wr_data <= sel_data;
          cfg_wr_en   <= sel_wr;
          cfg_rd_en   <= ~sel_wr;
          state       <= ISSUE;
        end
        ISSUE:   state <= is_wr ? IDLE : RD_WAIT;
        RD_WAIT: if (cfg_rd_data_valid || tmo_expired) begin
          if (owner) begin
            req1_rd_data       <= ret_data;
            req1_rd_data_valid <= 1'b1;
          end else begin
            req0_rd_data       <= ret_data;
            req0_rd_data_valid <= 1'b1;
          end
          state <= RETURN;
        end
        RETURN:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_cfg_arbiter.sv
// Bench for glb_cfg_arbiter: timeline-level model checked every cycle plus directed literal checks.
module tb_glb_cfg_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TMO = 64;
  localparam int NEVER = 32'h3fff_ffff;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_wr_en = 0, req0_rd_en = 0, req1_wr_en = 0, req1_rd_en = 0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wr_data = '0, req1_wr_data = '0;
  logic          req0_ready, req1_ready, req0_rd_data_valid, req1_rd_data_valid;
  logic [DW-1:0] req0_rd_data, req1_rd_data;
  logic          cfg_wr_en, cfg_wr_clk_en, cfg_rd_en, cfg_rd_clk_en;
  logic [AW-1:0] cfg_wr_addr, cfg_rd_addr;
  logic [DW-1:0] cfg_wr_data;
  logic [DW-1:0] cfg_rd_data = '0;
  logic          cfg_rd_data_valid = 1'b0;
  logic          rd_timeout_err;

  always #5 clk = ~clk;

  glb_cfg_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req0_wr_en(req0_wr_en), .req0_rd_en(req0_rd_en), .req0_addr(req0_addr),
    .req0_wr_data(req0_wr_data), .req0_ready(req0_ready), .req0_rd_data(req0_rd_data),
    .req0_rd_data_valid(req0_rd_data_valid),
    .req1_wr_en(req1_wr_en), .req1_rd_en(req1_rd_en), .req1_addr(req1_addr),
    .req1_wr_data(req1_wr_data), .req1_ready(req1_ready), .req1_rd_data(req1_rd_data),
    .req1_rd_data_valid(req1_rd_data_valid),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_clk_en(cfg_wr_clk_en), .cfg_rd_en(cfg_rd_en),
    .cfg_rd_clk_en(cfg_rd_clk_en), .cfg_wr_addr(cfg_wr_addr), .cfg_rd_addr(cfg_rd_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_rd_data(cfg_rd_data),
    .cfg_rd_data_valid(cfg_rd_data_valid), .rd_timeout_err(rd_timeout_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: DUT event did not occur within bound (cycle %0d)", name, cyc);
  endtask

  // Timeline model: when the port is free, which cycle each strobe/return lands on.
  bit            m_lastg, m_rd_wait, m_stb_wr, m_owner, m_ret_owner, m_ret_err;
  int            m_free_at, m_rd_issue, m_stb_cyc, m_ret_cyc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata [2];

  always @(negedge clk) begin : model
    bit p [2];
    bit g, free;
    if (reset) begin
      chk("rst_ready0", req0_ready, 0);          chk("rst_ready1", req1_ready, 0);
      chk("rst_cfg_wr_en", cfg_wr_en, 0);        chk("rst_cfg_rd_en", cfg_rd_en, 0);
      chk("rst_cfg_wr_clk_en", cfg_wr_clk_en, 0); chk("rst_cfg_rd_clk_en", cfg_rd_clk_en, 0);
      chk("rst_cfg_wr_addr", cfg_wr_addr, 0);    chk("rst_cfg_rd_addr", cfg_rd_addr, 0);
      chk("rst_cfg_wr_data", cfg_wr_data, 0);
      chk("rst_rd_data0", req0_rd_data, 0);      chk("rst_rd_data1", req1_rd_data, 0);
      chk("rst_rd_vld0", req0_rd_data_valid, 0); chk("rst_rd_vld1", req1_rd_data_valid, 0);
      chk("rst_tmo_err", rd_timeout_err, 0);
      m_lastg = 1; m_free_at = 0; m_rd_wait = 0; m_stb_cyc = -1; m_stb_wr = 0;
      m_ret_cyc = -1; m_ret_err = 0; m_ret_owner = 0; m_owner = 0;
      m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    end else begin
      p[0] = req0_wr_en | req0_rd_en;
      p[1] = req1_wr_en | req1_rd_en;
      chk("legal_req0", req0_wr_en & req0_rd_en, 0);
      chk("legal_req1", req1_wr_en & req1_rd_en, 0);
      free = (cyc >= m_free_at);
      g = p[!m_lastg] ? !m_lastg : m_lastg;
      chk("ready0", req0_ready, free && (p[0] || p[1]) && !g);
      chk("ready1", req1_ready, free && (p[0] || p[1]) && g);
      chk("cfg_wr_en", cfg_wr_en, (cyc == m_stb_cyc) && m_stb_wr);
      chk("cfg_wr_clk_en", cfg_wr_clk_en, (cyc == m_stb_cyc) && m_stb_wr);
      chk("cfg_rd_en", cfg_rd_en, (cyc == m_stb_cyc) && !m_stb_wr);
      chk("cfg_rd_clk_en", cfg_rd_clk_en, (cyc == m_stb_cyc) && !m_stb_wr);
      chk("cfg_wr_addr", cfg_wr_addr, m_addr);
      chk("cfg_rd_addr", cfg_rd_addr, m_addr);
      chk("cfg_wr_data", cfg_wr_data, m_wdata);
      chk("rd_data0", req0_rd_data, m_rdata[0]);
      chk("rd_data1", req1_rd_data, m_rdata[1]);
      chk("rd_vld0", req0_rd_data_valid, (cyc == m_ret_cyc) && !m_ret_owner);
      chk("rd_vld1", req1_rd_data_valid, (cyc == m_ret_cyc) && m_ret_owner);
      chk("tmo_err", rd_timeout_err, (cyc == m_ret_cyc) && m_ret_err);

      if (m_rd_wait) begin
        if (cfg_rd_data_valid && cyc > m_rd_issue) begin
          m_rdata[m_owner] = cfg_rd_data;
          m_ret_cyc = cyc + 1; m_ret_owner = m_owner; m_ret_err = 0;
          m_free_at = cyc + 2; m_rd_wait = 0;
        end
`ifdef GLB_CFG_ARB_TIMEOUT_EN
        else if (cyc == m_rd_issue + TMO) begin
          m_rdata[m_owner] = '1;
          m_ret_cyc = cyc + 1; m_ret_owner = m_owner; m_ret_err = 1;
          m_free_at = cyc + 2; m_rd_wait = 0;
        end
`endif
      end
      if (free && (p[0] || p[1])) begin
        m_lastg = g; m_owner = g;
        m_addr  = g ? req1_addr : req0_addr;
        m_wdata = g ? req1_wr_data : req0_wr_data;
        m_stb_wr = g ? req1_wr_en : req0_wr_en;
        m_stb_cyc = cyc + 1;
        if (m_stb_wr) m_free_at = cyc + 2;
        else begin
          m_free_at = NEVER; m_rd_wait = 1; m_rd_issue = cyc + 1;
        end
      end
    end
  end

  task automatic set_req(input int n, input bit wr, input bit rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (n == 0) begin req0_wr_en = wr; req0_rd_en = rd; req0_addr = a; req0_wr_data = d; end
    else        begin req1_wr_en = wr; req1_rd_en = rd; req1_addr = a; req1_wr_data = d; end
  endtask

  task automatic do_req(input int n, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int t);
    @(posedge clk); #1;
    set_req(n, wr, !wr, a, d);
    t = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) begin t = cyc; break; end
    end
    if (t < 0) bound_fail("req_ready");
    @(posedge clk); #1;
    set_req(n, 0, 0, '0, '0);
  endtask

  task automatic slave_resp(input int delay, input bit spurious, input logic [DW-1:0] d,
                            output int icyc, output int vcyc);
    icyc = -1; vcyc = -1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (cfg_rd_en) begin icyc = cyc; break; end
    end
    if (icyc < 0) begin bound_fail("slave_rd_en"); return; end
    if (spurious) begin cfg_rd_data_valid = 1; cfg_rd_data = 32'h0000_0BAD; end
    for (int k = 1; k <= delay; k++) begin
      @(posedge clk); #1;
      cfg_rd_data_valid = (k == delay);
      cfg_rd_data = (k == delay) ? d : '0;
    end
    vcyc = cyc;
    @(posedge clk); #1;
    cfg_rd_data_valid = 0; cfg_rd_data = '0;
  endtask

  task automatic wait_ret(input int n, output int c, output logic [DW-1:0] d, output logic e);
    c = -1; d = '0; e = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if ((n == 0) ? req0_rd_data_valid : req1_rd_data_valid) begin
        c = cyc; d = (n == 0) ? req0_rd_data : req1_rd_data; e = rd_timeout_err; break;
      end
    end
    if (c < 0) bound_fail("rd_return");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, t0, t1, ic, vc, rc, nv;
    logic [DW-1:0] rd;
    logic re;
    // Reset with a request present: ready must stay low.
    req0_wr_en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_ready0", req0_ready, 0);
    chk("lit_rst_wr_en", cfg_wr_en, 0);
    @(posedge clk); #1;
    req0_wr_en = 0;
    reset = 0;

    // Both write continuously: grants 0,1,0,1 two cycles apart.
    @(posedge clk); #1;
    set_req(0, 1, 0, 12'h100, 32'h0000_00A0);
    set_req(1, 1, 0, 12'h200, 32'h0000_00B0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("lit_alt_grant%0d", i), {req1_ready, req0_ready},
          (i % 2) ? 2'b00 : ((i % 4 == 0) ? 2'b01 : 2'b10));
      if (i % 2) chk($sformatf("lit_alt_addr%0d", i), cfg_wr_addr, (i % 4 == 1) ? 12'h100 : 12'h200);
    end
    @(posedge clk); #1;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);

    // Single write from req0.
    do_req(0, 1, 12'h123, 32'hCAFE_F00D, t);
    @(negedge clk);
    chk("lit_wr_en_t1", cfg_wr_en, 1);
    chk("lit_wr_addr", cfg_wr_addr, 12'h123);
    chk("lit_wr_data", cfg_wr_data, 32'hCAFE_F00D);
    chk("lit_wr_no_rd", cfg_rd_en, 0);
    @(negedge clk);
    chk("lit_wr_en_t2", cfg_wr_en, 0);

    // req1 read, slave answers 3 cycles after cfg_rd_en.
    fork
      do_req(1, 0, 12'h040, '0, t1);
      slave_resp(3, 0, 32'h1234_5678, ic, vc);
      wait_ret(1, rc, rd, re);
    join
    chk("lit_rd_issue", ic, t1 + 1);
    chk("lit_rd_ret_cyc", rc, ic + 4);
    chk("lit_rd_data", rd, 32'h1234_5678);
    chk("lit_rd_req0_data", req0_rd_data, 0);

    // Read outstanding (with a valid coincident with cfg_rd_en), req0 write waits.
    fork
      do_req(1, 0, 12'h055, '0, t1);
      begin @(posedge clk); do_req(0, 1, 12'h321, 32'hDEAD_BEEF, t0); end
      slave_resp(4, 1, 32'h0BAD_F00D, ic, vc);
      wait_ret(1, rc, rd, re);
    join
    chk("lit_ow_ret_cyc", rc, vc + 1);
    chk("lit_ow_ret_data", rd, 32'h0BAD_F00D);
    chk("lit_ow_wr_grant", t0, vc + 2);

`ifdef GLB_CFG_ARB_TIMEOUT_EN
    fork
      do_req(0, 0, 12'h0AB, '0, t);
      wait_ret(0, rc, rd, re);
    join
    chk("lit_tmo_cyc", rc, t + 2 + TMO);
    chk("lit_tmo_data", rd, 32'hFFFF_FFFF);
    chk("lit_tmo_err", re, 1);
    do_req(1, 0, 12'h077, '0, t);
`else
    do_req(0, 0, 12'h0AB, '0, t);
    nv = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      nv += int'(req0_rd_data_valid) + int'(rd_timeout_err) + int'(req0_ready) + int'(req1_ready);
    end
    chk("lit_no_tmo_activity", nv, 0);
`endif

    // Reset mid RD_WAIT, then a late slave valid.
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("lit_midrst_addr", cfg_rd_addr, 0);
    chk("lit_midrst_rd_data1", req1_rd_data, 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    cfg_rd_data_valid = 1; cfg_rd_data = 32'h5555_5555;
    @(posedge clk); #1;
    cfg_rd_data_valid = 0; cfg_rd_data = '0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      nv += int'(req0_rd_data_valid) + int'(req1_rd_data_valid);
    end
    chk("lit_late_valid_ignored", nv, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
